// File: rtl/pipeline_register_exmem.sv
// EX/MEM pipeline register for the 5-stage MIPS core.
//
// Captures the EX-stage ALU result, store data, control bits and branch/jump
// targets on each rising edge. Branch/jump outcomes are resolved
// combinationally from the registered contents and drive the PC redirect and
// the upstream squash. Supports stall (hold), external flush and automatic
// wrong-path squash, and keeps a saturating count of taken redirects.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall_i, flush_i      hold contents / load a bubble
//   valid_i               EX-stage instruction is real
//   branch_eq_i .. reg_write_i, zero_i       control bits and ALU zero flag
//   alu_result_i, write_data_i, branch_target_i, jmp_target_i, pc_i,
//   write_register_i      EX-stage datapath fields
//   *_o (same names)      registered copies of the above
//   pc_src_o              redirect PC this cycle
//   redirect_pc_o         redirect address
//   flush_upstream_o      squash IF/ID and ID/EX contents
//   redirect_count_o      redirects taken since reset (saturating)

module pipeline_register_exmem #(
  parameter bit          FLUSH_ENABLE = 1'b1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic                 branch_eq_i,
  input  logic                 branch_ne_i,
  input  logic                 jmp_i,
  input  logic                 mem_to_reg_i,
  input  logic                 mem_write_i,
  input  logic                 mem_read_i,
  input  logic                 reg_write_i,
  input  logic                 zero_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          write_data_i,
  input  logic [31:0]          branch_target_i,
  input  logic [27:0]          jmp_target_i,
  input  logic [31:0]          pc_i,
  input  logic [4:0]           write_register_i,
  output logic                 valid_o,
  output logic                 branch_eq_o,
  output logic                 branch_ne_o,
  output logic                 jmp_o,
  output logic                 mem_to_reg_o,
  output logic                 mem_write_o,
  output logic                 mem_read_o,
  output logic                 reg_write_o,
  output logic                 zero_o,
  output logic [31:0]          alu_result_o,
  output logic [31:0]          write_data_o,
  output logic [31:0]          branch_target_o,
  output logic [27:0]          jmp_target_o,
  output logic [31:0]          pc_o,
  output logic [4:0]           write_register_o,
  output logic                 pc_src_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 flush_upstream_o,
  output logic [CNT_WIDTH-1:0] redirect_count_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned JT_W   = 28;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 7;

  // Control bit order: {branch_eq, branch_ne, jmp, mem_to_reg, mem_write,
  // mem_read, reg_write}
  logic                 r_valid;
  logic [CTRL_W-1:0]    r_ctrl;
  logic                 r_zero;
  logic [DATA_W-1:0]    r_alu_result;
  logic [DATA_W-1:0]    r_write_data;
  logic [DATA_W-1:0]    r_branch_target;
  logic [JT_W-1:0]      r_jmp_target;
  logic [DATA_W-1:0]    r_pc;
  logic [REG_W-1:0]     r_write_register;
  logic [CNT_WIDTH-1:0] r_redirect_count;

  logic                 w_br_taken;
  logic                 w_jmp_taken;
  logic                 w_pc_src;
  logic                 w_flush;
  logic                 w_cnt_sat;
  logic [CTRL_W-1:0]    w_ctrl_in;
  logic [DATA_W-1:0]    w_redirect_pc;

  // Bubbles never carry live control bits, whatever EX presents.
  assign w_ctrl_in = valid_i
                   ? {branch_eq_i, branch_ne_i, jmp_i, mem_to_reg_i,
                      mem_write_i, mem_read_i, reg_write_i}
                   : '0;

  // Branch/jump resolution from registered state only.
  assign w_br_taken  = r_valid & ((r_ctrl[6] & r_zero) | (r_ctrl[5] & ~r_zero));
  assign w_jmp_taken = r_valid & r_ctrl[4];
  assign w_pc_src    = w_br_taken | w_jmp_taken;

  // Jump wins over a branch when both are set.
  assign w_redirect_pc = w_jmp_taken ? {r_pc[31:28], r_jmp_target}
                                     : r_branch_target;

  // A redirect squashes the instruction now in EX, so it doubles as a flush.
  assign w_flush = FLUSH_ENABLE & (flush_i | w_pc_src);

  assign w_cnt_sat = &r_redirect_count;

  // Pipeline contents: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid          <= 1'b0;
      r_ctrl           <= '0;
      r_zero           <= 1'b0;
      r_alu_result     <= '0;
      r_write_data     <= '0;
      r_branch_target  <= '0;
      r_jmp_target     <= '0;
      r_pc             <= '0;
      r_write_register <= '0;
    end else if (w_flush) begin
      r_valid          <= 1'b0;
      r_ctrl           <= '0;
      r_zero           <= 1'b0;
      r_alu_result     <= '0;
      r_write_data     <= '0;
      r_branch_target  <= '0;
      r_jmp_target     <= '0;
      r_pc             <= '0;
      r_write_register <= '0;
    end else if (!stall_i) begin
      r_valid          <= valid_i;
      r_ctrl           <= w_ctrl_in;
      r_zero           <= zero_i;
      r_alu_result     <= alu_result_i;
      r_write_data     <= write_data_i;
      r_branch_target  <= branch_target_i;
      r_jmp_target     <= jmp_target_i;
      r_pc             <= pc_i;
      r_write_register <= write_register_i;
    end
  end

  // Saturating redirect counter; counts every redirect cycle, including
  // repeated cycles of a stalled taken branch when squash is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_count <= '0;
    end else if (w_pc_src && !w_cnt_sat) begin
      r_redirect_count <= r_redirect_count + CNT_WIDTH'(1);
    end
  end

  assign valid_o          = r_valid;
  assign branch_eq_o      = r_ctrl[6];
  assign branch_ne_o      = r_ctrl[5];
  assign jmp_o            = r_ctrl[4];
  assign mem_to_reg_o     = r_ctrl[3];
  assign mem_write_o      = r_ctrl[2];
  assign mem_read_o       = r_ctrl[1];
  assign reg_write_o      = r_ctrl[0];
  assign zero_o           = r_zero;
  assign alu_result_o     = r_alu_result;
  assign write_data_o     = r_write_data;
  assign branch_target_o  = r_branch_target;
  assign jmp_target_o     = r_jmp_target;
  assign pc_o             = r_pc;
  assign write_register_o = r_write_register;
  assign redirect_count_o = r_redirect_count;

  assign pc_src_o         = w_pc_src;
  assign redirect_pc_o    = w_redirect_pc;
  assign flush_upstream_o = w_pc_src & FLUSH_ENABLE;

endmodule

// File: tb/tb_pipeline_register_exmem.sv
// Bench for pipeline_register_exmem: one instance with squash enabled and a
// 16-bit counter, one with squash disabled and a 2-bit counter, both driven
// by the same stimulus and each checked against its own reference model.

module tb_pipeline_register_exmem;

  typedef struct packed {
    logic        valid;
    logic [6:0]  ctrl;   // {beq, bne, jmp, m2r, mw, mr, rw}
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] bt;
    logic [27:0] jt;
    logic [31:0] pc;
    logic [4:0]  wr;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  fields_t din = '0;

  logic        o_valid [2];
  logic        o_beq [2];
  logic        o_bne [2];
  logic        o_jmp [2];
  logic        o_m2r [2];
  logic        o_mw [2];
  logic        o_mr [2];
  logic        o_rw [2];
  logic        o_zero [2];
  logic [31:0] o_alu [2];
  logic [31:0] o_wd [2];
  logic [31:0] o_bt [2];
  logic [27:0] o_jt [2];
  logic [31:0] o_pc [2];
  logic [4:0]  o_wr [2];
  logic        o_src [2];
  logic [31:0] o_rpc [2];
  logic        o_fu [2];
  logic [15:0] o_cnt_a;
  logic [1:0]  o_cnt_b;

  int checks = 0;
  int failures = 0;

  // Reference model state
  fields_t ms [2];
  int      mcnt [2];
  int      cmax [2];

  always #5 clk = ~clk;

  pipeline_register_exmem #(.FLUSH_ENABLE(1'b1), .CNT_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(din.valid),
    .branch_eq_i(din.ctrl[6]), .branch_ne_i(din.ctrl[5]), .jmp_i(din.ctrl[4]),
    .mem_to_reg_i(din.ctrl[3]), .mem_write_i(din.ctrl[2]),
    .mem_read_i(din.ctrl[1]), .reg_write_i(din.ctrl[0]),
    .zero_i(din.zero), .alu_result_i(din.alu), .write_data_i(din.wd),
    .branch_target_i(din.bt), .jmp_target_i(din.jt), .pc_i(din.pc),
    .write_register_i(din.wr),
    .valid_o(o_valid[0]), .branch_eq_o(o_beq[0]), .branch_ne_o(o_bne[0]),
    .jmp_o(o_jmp[0]), .mem_to_reg_o(o_m2r[0]), .mem_write_o(o_mw[0]),
    .mem_read_o(o_mr[0]), .reg_write_o(o_rw[0]), .zero_o(o_zero[0]),
    .alu_result_o(o_alu[0]), .write_data_o(o_wd[0]),
    .branch_target_o(o_bt[0]), .jmp_target_o(o_jt[0]), .pc_o(o_pc[0]),
    .write_register_o(o_wr[0]), .pc_src_o(o_src[0]),
    .redirect_pc_o(o_rpc[0]), .flush_upstream_o(o_fu[0]),
    .redirect_count_o(o_cnt_a)
  );

  pipeline_register_exmem #(.FLUSH_ENABLE(1'b0), .CNT_WIDTH(2)) u_dut_b (
    .clk(clk), .reset(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(din.valid),
    .branch_eq_i(din.ctrl[6]), .branch_ne_i(din.ctrl[5]), .jmp_i(din.ctrl[4]),
    .mem_to_reg_i(din.ctrl[3]), .mem_write_i(din.ctrl[2]),
    .mem_read_i(din.ctrl[1]), .reg_write_i(din.ctrl[0]),
    .zero_i(din.zero), .alu_result_i(din.alu), .write_data_i(din.wd),
    .branch_target_i(din.bt), .jmp_target_i(din.jt), .pc_i(din.pc),
    .write_register_i(din.wr),
    .valid_o(o_valid[1]), .branch_eq_o(o_beq[1]), .branch_ne_o(o_bne[1]),
    .jmp_o(o_jmp[1]), .mem_to_reg_o(o_m2r[1]), .mem_write_o(o_mw[1]),
    .mem_read_o(o_mr[1]), .reg_write_o(o_rw[1]), .zero_o(o_zero[1]),
    .alu_result_o(o_alu[1]), .write_data_o(o_wd[1]),
    .branch_target_o(o_bt[1]), .jmp_target_o(o_jt[1]), .pc_o(o_pc[1]),
    .write_register_o(o_wr[1]), .pc_src_o(o_src[1]),
    .redirect_pc_o(o_rpc[1]), .flush_upstream_o(o_fu[1]),
    .redirect_count_o(o_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Is the instruction held in s redirecting the PC?
  function automatic bit taken(fields_t s);
    bit is_branch = (s.ctrl[6] && s.zero) || (s.ctrl[5] && !s.zero);
    return s.valid && (is_branch || s.ctrl[4]);
  endfunction

  function automatic logic [31:0] target(fields_t s);
    if (s.valid && s.ctrl[4]) return {s.pc[31:28], s.jt};
    return s.bt;
  endfunction

  // Advance one model by one clock edge using the current inputs.
  task automatic model_edge(input int k);
    bit fe  = (k == 0);
    bit red = taken(ms[k]);
    if (rst) begin
      ms[k]   = '0;
      mcnt[k] = 0;
    end else begin
      if (red && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
      if (fe && (flush || red)) ms[k] = '0;
      else if (!stall) begin
        ms[k] = din;
        if (!din.valid) ms[k].ctrl = '0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      fields_t s = ms[k];
      bit red = taken(s);
      logic [31:0] cnt_obs = (k == 0) ? {16'd0, o_cnt_a} : {30'd0, o_cnt_b};
      chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(s.valid));
      chk($sformatf("ctrl%0d", k),
          32'({o_beq[k], o_bne[k], o_jmp[k], o_m2r[k], o_mw[k], o_mr[k], o_rw[k]}),
          32'(s.ctrl));
      chk($sformatf("zero%0d", k), 32'(o_zero[k]), 32'(s.zero));
      chk($sformatf("alu%0d", k), o_alu[k], s.alu);
      chk($sformatf("wd%0d", k), o_wd[k], s.wd);
      chk($sformatf("bt%0d", k), o_bt[k], s.bt);
      chk($sformatf("jt%0d", k), 32'(o_jt[k]), 32'(s.jt));
      chk($sformatf("pc%0d", k), o_pc[k], s.pc);
      chk($sformatf("wr%0d", k), 32'(o_wr[k]), 32'(s.wr));
      chk($sformatf("pc_src%0d", k), 32'(o_src[k]), 32'(red));
      chk($sformatf("flush_up%0d", k), 32'(o_fu[k]), 32'(red && (k == 0)));
      if (red) chk($sformatf("rpc%0d", k), o_rpc[k], target(s));
      chk($sformatf("cnt%0d", k), cnt_obs, 32'(mcnt[k]));
    end
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    din   = '0;
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic rand_din();
    din.valid = ($urandom_range(0, 3) != 0);
    din.ctrl  = 7'($urandom);
    if ($urandom_range(0, 2) != 0) din.ctrl[4] = 1'b0;
    din.zero  = 1'($urandom);
    din.alu   = $urandom;
    din.wd    = $urandom;
    din.bt    = $urandom;
    din.jt    = 28'($urandom);
    din.pc    = $urandom;
    din.wr    = 5'($urandom);
  endtask

  initial begin
    cmax[0] = 65535;
    cmax[1] = 3;
    ms[0] = '0;
    ms[1] = '0;
    mcnt[0] = 0;
    mcnt[1] = 0;

    // Reset with every input high
    din = '1; rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_pc_src", 32'(o_src[0]), 32'd0);
    chk("rst_alu", o_alu[0], 32'd0);
    chk("rst_cnt", 32'(o_cnt_a), 32'd0);

    // Load and latency
    idle();
    din.valid = 1'b1; din.alu = 32'h0000_1234; din.wr = 5'd5; din.ctrl[0] = 1'b1;
    step();
    chk("load_alu", o_alu[0], 32'h0000_1234);
    chk("load_wr", 32'(o_wr[0]), 32'd5);
    chk("load_rw", 32'(o_rw[0]), 32'd1);
    chk("load_pc_src", 32'(o_src[0]), 32'd0);

    // Taken beq, then auto-squash
    idle();
    din.valid = 1'b1; din.ctrl[6] = 1'b1; din.zero = 1'b1; din.bt = 32'h0040_0020;
    step();
    chk("beq_src", 32'(o_src[0]), 32'd1);
    chk("beq_rpc", o_rpc[0], 32'h0040_0020);
    chk("beq_fu", 32'(o_fu[0]), 32'd1);
    idle();
    din.valid = 1'b1; din.alu = 32'h5555_0000;
    step();
    chk("squash_valid", 32'(o_valid[0]), 32'd0);
    chk("squash_src", 32'(o_src[0]), 32'd0);
    chk("squash_cnt", 32'(o_cnt_a), 32'd1);

    // Jump, and jump beating a taken bne
    idle();
    din.valid = 1'b1; din.ctrl[4] = 1'b1; din.pc = 32'h1000_0004; din.jt = 28'h100;
    step();
    chk("jmp_rpc", o_rpc[0], 32'h1000_0100);
    idle();
    step();
    din.valid = 1'b1; din.ctrl[4] = 1'b1; din.ctrl[5] = 1'b1; din.zero = 1'b0;
    din.pc = 32'h1000_0004; din.jt = 28'h100; din.bt = 32'h0BAD_0000;
    step();
    chk("jmp_bne_rpc", o_rpc[0], 32'h1000_0100);
    idle();
    step();

    // Store, stall three cycles, then stall plus flush
    din.valid = 1'b1; din.ctrl[2] = 1'b1; din.alu = 32'h0000_2000; din.wd = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      rand_din();
      stall = 1'b1;
      step();
      chk("stall_alu", o_alu[0], 32'h0000_2000);
      chk("stall_mw", 32'(o_mw[0]), 32'd1);
    end
    flush = 1'b1;
    step();
    chk("sf_valid", 32'(o_valid[0]), 32'd0);
    chk("sf_mw", 32'(o_mw[0]), 32'd0);
    chk("sf_b_hold", 32'(o_mw[1]), 32'd1);

    // Squash disabled: flush ignored, stalled bne repeats
    idle(); rst = 1'b1;
    step();
    idle(); flush = 1'b1; din.valid = 1'b1; din.alu = 32'h0000_ABCD;
    step();
    chk("nofl_alu_b", o_alu[1], 32'h0000_ABCD);
    chk("nofl_alu_a", o_alu[0], 32'd0);
    idle(); din.valid = 1'b1; din.ctrl[5] = 1'b1; din.zero = 1'b0; din.bt = 32'h0000_0040;
    step();
    chk("bne_src1", 32'(o_src[1]), 32'd1);
    stall = 1'b1;
    step();
    chk("bne_src2", 32'(o_src[1]), 32'd1);
    chk("bne_cnt1", 32'(o_cnt_b), 32'd1);
    idle();
    step();
    chk("bne_src_done", 32'(o_src[1]), 32'd0);
    chk("bne_cnt2", 32'(o_cnt_b), 32'd2);
    din.valid = 1'b1; din.ctrl[5] = 1'b1; din.zero = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_sat", 32'(o_cnt_b), 32'd3);

    // Reset during a stalled redirect
    idle(); din.valid = 1'b1; din.ctrl[6] = 1'b1; din.zero = 1'b1;
    step();
    rst = 1'b1; stall = 1'b1;
    step();
    chk("rst_mid_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_mid_src", 32'(o_src[1]), 32'd0);
    idle();
    step();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      rand_din();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
